// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, MEM), the arbiter and the unified RAM.
// slave is the arbiter's view; master is the pipeline/RAM side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              if_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              mem_stall;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              arb_busy;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
      output ram_en, ram_we, ram_addr, ram_wdata, arb_busy
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
      input  ram_en, ram_we, ram_addr, ram_wdata, arb_busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported RAM between instruction fetch and the
// MEM stage; one access in flight, one-cycle done pulse, alternating grants under contention.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_grant;
   logic              w_grant_mem;

   logic [CNT_W-1:0]  r_cnt;
   logic              r_last_mem;   // last grant went to MEM; also the current owner
   logic              r_ram_en;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_if_done;
   logic              r_mem_done;
   logic              r_busy;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next state and grant decision; MEM wins contention unless it had the previous grant
   always_comb begin
      w_next      = r_state;
      w_grant     = 1'b0;
      w_grant_mem = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.if_req || bus.mem_req) begin
               w_grant     = 1'b1;
               w_grant_mem = bus.mem_req && (!bus.if_req || !r_last_mem);
               w_next      = S_ISSUE;
            end
         end
         S_ISSUE: w_next = (MEM_LAT == 1) ? S_DONE : S_WAIT;
         S_WAIT:  if (r_cnt == CNT_W'(1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: RAM command latched at grant and held until the next grant
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_last_mem  <= 1'b0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_ram_en   <= (w_next == S_ISSUE);
         r_busy     <= (w_next != S_IDLE);
         r_if_done  <= (w_next == S_DONE) && !r_last_mem;
         r_mem_done <= (w_next == S_DONE) && r_last_mem;
         if (r_state == S_ISSUE)     r_cnt <= CNT_W'(MEM_LAT - 1);
         else if (r_state == S_WAIT) r_cnt <= r_cnt - CNT_W'(1);
         if (w_grant) begin
            r_last_mem  <= w_grant_mem;
            r_ram_we    <= w_grant_mem && bus.mem_we;
            r_ram_addr  <= w_grant_mem ? bus.mem_addr  : bus.if_addr;
            r_ram_wdata <= w_grant_mem ? bus.mem_wdata : DATA_W'(0);
         end
      end
   end

   assign bus.ram_en    = r_ram_en;
   assign bus.ram_we    = r_ram_we;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.arb_busy  = r_busy;
   assign bus.if_done   = r_if_done;
   assign bus.mem_done  = r_mem_done;

   // Read data passes through only during the owner's done cycle; stores return zero
   assign bus.if_rdata  = r_if_done ? bus.ram_rdata : DATA_W'(0);
   assign bus.mem_rdata = (r_mem_done && !r_ram_we) ? bus.ram_rdata : DATA_W'(0);

   assign bus.if_stall  = bus.if_req  && !r_if_done;
   assign bus.mem_stall = bus.mem_req && !r_mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the main sequence and a
// MEM_LAT=1 instance for the short-latency path.
module tb_mem_port_arbiter;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] grant_addr [4];
   logic        grant_mem  [4];
   int          en_cnt;
   int          done_cnt;
   int          wrong_done;

   initial begin
      total = 0;
      bad   = 0;
      grant_addr[0] = 32'h300; grant_mem[0] = 1'b1;
      grant_addr[1] = 32'h200; grant_mem[1] = 1'b0;
      grant_addr[2] = 32'h300; grant_mem[2] = 1'b1;
      grant_addr[3] = 32'h200; grant_mem[3] = 1'b0;

      reset = 1'b1;
      bus0.if_req = 0; bus0.if_addr = '0; bus0.mem_req = 0; bus0.mem_we = 0;
      bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.ram_rdata = '0;
      bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_req = 0; bus1.mem_we = 0;
      bus1.mem_addr = '0; bus1.mem_wdata = '0; bus1.ram_rdata = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy",   64'(bus0.arb_busy),  64'd0);
      chk("rst_en",     64'(bus0.ram_en),    64'd0);
      chk("rst_we",     64'(bus0.ram_we),    64'd0);
      chk("rst_addr",   64'(bus0.ram_addr),  64'd0);
      chk("rst_wdata",  64'(bus0.ram_wdata), 64'd0);
      chk("rst_ifdone", 64'(bus0.if_done),   64'd0);
      chk("rst_mdone",  64'(bus0.mem_done),  64'd0);

      // Test 1: uncontended fetch (c0)
      reset = 1'b0;
      bus0.if_req = 1; bus0.if_addr = 32'h10; bus0.ram_rdata = 32'h8C010004;
      #1;
      chk("t1_stall_c0", 64'(bus0.if_stall), 64'd1);
      tick(); // c1
      chk("t1_en_c1",    64'(bus0.ram_en),   64'd1);
      chk("t1_addr_c1",  64'(bus0.ram_addr), 64'h10);
      chk("t1_we_c1",    64'(bus0.ram_we),   64'd0);
      chk("t1_stall_c1", 64'(bus0.if_stall), 64'd1);
      tick(); // c2
      chk("t1_en_c2",    64'(bus0.ram_en),   64'd0);
      chk("t1_done_c2",  64'(bus0.if_done),  64'd0);
      chk("t1_stall_c2", 64'(bus0.if_stall), 64'd1);
      tick(); // c3
      chk("t1_done_c3",  64'(bus0.if_done),  64'd1);
      chk("t1_rdata_c3", 64'(bus0.if_rdata), 64'h8C010004);
      chk("t1_stall_c3", 64'(bus0.if_stall), 64'd0);
      bus0.if_req = 0;
      tick(); // c4
      chk("t1_done_c4",  64'(bus0.if_done),  64'd0);
      chk("t1_rdata_c4", 64'(bus0.if_rdata), 64'd0);
      chk("t1_busy_c4",  64'(bus0.arb_busy), 64'd0);

      // Test 2: simultaneous IF and lw, MEM first (d0 = c4)
      bus0.if_req = 1; bus0.if_addr = 32'h44;
      bus0.mem_req = 1; bus0.mem_we = 0; bus0.mem_addr = 32'h100;
      bus0.ram_rdata = 32'h11112222;
      tick(); // d1
      chk("t2_en_d1",   64'(bus0.ram_en),   64'd1);
      chk("t2_addr_d1", 64'(bus0.ram_addr), 64'h100);
      tick(); tick(); // d3
      chk("t2_mdone_d3",  64'(bus0.mem_done),  64'd1);
      chk("t2_mrdata_d3", 64'(bus0.mem_rdata), 64'h11112222);
      chk("t2_ifdone_d3", 64'(bus0.if_done),   64'd0);
      chk("t2_ifrd_d3",   64'(bus0.if_rdata),  64'd0);
      chk("t2_ifstl_d3",  64'(bus0.if_stall),  64'd1);
      bus0.mem_req = 0;
      tick(); tick(); // d5
      chk("t2_en_d5",   64'(bus0.ram_en),   64'd1);
      chk("t2_addr_d5", 64'(bus0.ram_addr), 64'h44);
      bus0.ram_rdata = 32'h33334444;
      tick(); // d6
      chk("t2_ifdone_d6", 64'(bus0.if_done), 64'd0);
      tick(); // d7
      chk("t2_ifdone_d7", 64'(bus0.if_done),  64'd1);
      chk("t2_ifrd_d7",   64'(bus0.if_rdata), 64'h33334444);
      bus0.if_req = 0;
      tick(); // d8

      // Test 3: continuous contention alternates MEM, IF, MEM, IF
      bus0.if_req = 1; bus0.if_addr = 32'h200;
      bus0.mem_req = 1; bus0.mem_we = 0; bus0.mem_addr = 32'h300;
      bus0.ram_rdata = 32'h0A0B0C0D;
      for (int k = 0; k < 4; k++) begin
         tick(); // issue
         chk($sformatf("t3_en_%0d", k),   64'(bus0.ram_en),   64'd1);
         chk($sformatf("t3_addr_%0d", k), 64'(bus0.ram_addr), 64'(grant_addr[k]));
         tick(); tick(); // done
         chk($sformatf("t3_mdone_%0d", k),  64'(bus0.mem_done),  64'(grant_mem[k]));
         chk($sformatf("t3_ifdone_%0d", k), 64'(bus0.if_done),   64'(!grant_mem[k]));
         chk($sformatf("t3_mstl_%0d", k),   64'(bus0.mem_stall), 64'(!grant_mem[k]));
         chk($sformatf("t3_rdata_%0d", k),
             64'(grant_mem[k] ? bus0.mem_rdata : bus0.if_rdata), 64'h0A0B0C0D);
         if (k == 3) begin
            bus0.if_req = 0; bus0.mem_req = 0;
         end
         tick(); // idle
         chk($sformatf("t3_busy_%0d", k), 64'(bus0.arb_busy), 64'd0);
      end

      // Test 4: store
      bus0.mem_req = 1; bus0.mem_we = 1; bus0.mem_addr = 32'h20;
      bus0.mem_wdata = 32'hDEADBEEF; bus0.ram_rdata = 32'h55555555;
      en_cnt = 0; wrong_done = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (bus0.if_done) wrong_done++;
         if (bus0.ram_en) begin
            en_cnt++;
            chk("t4_we",    64'(bus0.ram_we),    64'd1);
            chk("t4_addr",  64'(bus0.ram_addr),  64'h20);
            chk("t4_wdata", 64'(bus0.ram_wdata), 64'hDEADBEEF);
         end
         if (i == 3) begin
            chk("t4_mdone",  64'(bus0.mem_done),  64'd1);
            chk("t4_mrdata", 64'(bus0.mem_rdata), 64'd0);
            bus0.mem_req = 0; bus0.mem_we = 0;
         end
      end
      chk("t4_en_count", 64'(en_cnt),     64'd1);
      chk("t4_no_ifdn",  64'(wrong_done), 64'd0);

      // Test 5: IF drops request during WAIT; access still completes
      bus0.if_req = 1; bus0.if_addr = 32'h80; bus0.ram_rdata = 32'h77;
      done_cnt = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (bus0.if_done) done_cnt++;
         if (i == 2) bus0.if_req = 0;
         if (i == 3) chk("t5_addr_done", 64'(bus0.ram_addr), 64'h80);
      end
      chk("t5_done_count", 64'(done_cnt),      64'd1);
      chk("t5_busy_end",   64'(bus0.arb_busy), 64'd0);

      // Test 6: reset during WAIT
      bus0.mem_req = 1; bus0.mem_we = 0; bus0.mem_addr = 32'h40;
      tick(); // issue
      chk("t6_en_issue", 64'(bus0.ram_en), 64'd1);
      tick(); // wait
      reset = 1'b1; bus0.mem_req = 0;
      tick();
      chk("t6_busy", 64'(bus0.arb_busy), 64'd0);
      chk("t6_en",   64'(bus0.ram_en),   64'd0);
      chk("t6_mdn",  64'(bus0.mem_done), 64'd0);
      chk("t6_addr", 64'(bus0.ram_addr), 64'd0);
      reset = 1'b0;
      tick();
      chk("t6_mdn_after",  64'(bus0.mem_done), 64'd0);
      chk("t6_busy_after", 64'(bus0.arb_busy), 64'd0);

      // Test 6b: MEM_LAT=1 goes ISSUE -> DONE (j0)
      bus1.if_req = 1; bus1.if_addr = 32'h90; bus1.ram_rdata = 32'hCAFEF00D;
      tick(); // j1
      chk("t6b_en",    64'(bus1.ram_en),   64'd1);
      chk("t6b_addr",  64'(bus1.ram_addr), 64'h90);
      chk("t6b_dn_j1", 64'(bus1.if_done),  64'd0);
      tick(); // j2
      chk("t6b_dn_j2", 64'(bus1.if_done),  64'd1);
      chk("t6b_rdata", 64'(bus1.if_rdata), 64'hCAFEF00D);
      bus1.if_req = 0;
      tick(); // j3
      chk("t6b_busy",  64'(bus1.arb_busy), 64'd0);
      chk("t6b_dn_j3", 64'(bus1.if_done),  64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
